cpu_ctrl_unit: RTL
==================

// Module: cpu_ctrl_unit
// PURPOSE
//  Sequencer for the 16-bit accumulator datapath: fetch, decode, optional indirect, execute.
//  Decodes IR and drives one-hot op strobes and phase strobes (fetch/execute/is_ind/is_dir).
//  Waits for datapath completion (i_ex_done), counts retired instructions, stops on HLT.
//  Sits between the top-level run/stop control and the datapath.
// PARAMETERS
//  MEM_LAT     2   cycles from fetch or indirect strobe until i_ir / memory data valid
//  EX_TIMEOUT  15  max EXECUTE cycles waiting for i_ex_done before o_err (4-bit counter)
//  CNT_W       16  width of retired-instruction counter
// PORTS
//  clk            in   1      clock, rising edge
//  i_clr_reg      in   1      reset, asynchronous, active-high
//  i_start        in   1      level; sampled in IDLE/HALT, starts a run
//  i_ir           in   16     datapath IR (I=[15], op=[14:12], addr/bits=[11:0])
//  i_ex_done      in   1      datapath execute-complete
//  o_clr_reg      out  1      1-cycle datapath register clear on start
//  o_fetch        out  1      fetch phase strobe
//  o_execute      out  1      execute phase, held through EXECUTE
//  o_is_ind       out  1      indirect-address cycle strobe
//  o_is_dir       out  1      effective address resolved (memory-ref execute)
//  o_clr_ac,o_clr_e,o_comp_ac,o_load_ac,o_cir_r,o_cir_l,o_inc_ac  out 1  reg-ref strobes
//  o_add,o_load,o_store,o_branch,o_isz  out 1  memory-ref strobes
//  o_halted       out  1      HALT state reached
//  o_err          out  1      sticky: execute timeout
//  o_state        out  3      current state encoding (debug)
//  o_retired      out  CNT_W  instructions completed since start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; o_retired 0; o_err 0. Async assert, sync-to-clk release.
//  States: IDLE=0 FETCH=1 WAIT_IR=2 DECODE=3 INDIR=4 WAIT_EA=5 EXEC=6 HALT=7.
//  IDLE/HALT: i_start=1 -> o_clr_reg pulse 1 cycle, o_retired<=0, o_err<=0, next FETCH.
//  FETCH: o_fetch=1 for 1 cycle -> WAIT_IR; WAIT_IR counts MEM_LAT cycles -> DECODE.
//  DECODE (1 cycle): latch i_ir into op register; all later strobes use latched copy.
//   op 000 ADD, 001 LDA, 010 STA, 011 BUN, 100 ISZ: memory-ref.
//     I=1 -> INDIR (o_is_ind 1 cycle) -> WAIT_EA (MEM_LAT) -> EXEC; I=0 -> EXEC.
//   op 111,I=0: register-ref; priority bit11 CLA > 10 CLE > 9 CMA > 7 CIR > 6 CIL > 5 INC;
//     only the highest set bit strobes. bit0 HLT (no other bits considered) -> HALT, retires.
//   op 111,I=1: LDI -> o_load_ac (AC<=IR[7:0] in datapath).
//   op 101/110, or 111 I=0 with no valid bit: NOP; retire, -> FETCH, no strobes.
//  EXEC: o_execute=1 and selected op strobe held; o_is_dir=1 for memory-ref.
//   Exit when i_ex_done=1: strobes drop next cycle, o_retired+1 (wraps at 2^CNT_W-1 -> 0), -> FETCH.
//   i_ex_done already high on entry is ignored for first EXEC cycle (stale from prior instr).
//   Timeout counter reaches EX_TIMEOUT without done -> o_err=1, -> HALT, no retire.
//  HALT: o_halted=1; all strobes 0; leaves only via i_start (restart) or reset.
//  i_start ignored outside IDLE/HALT. Reset mid-instruction aborts immediately; no partial strobes.
//  Strobes registered (no combinational path from i_ir/i_ex_done to outputs).
//  At most one op strobe and at most one phase strobe (except execute+is_dir) high per cycle.
// STRUCTURE
//  cpu_ctrl_pkg: state localparams, opcode localparams (OP_ADD..OP_RREF), IR bit positions
//   (CLA=11 .. INC=5, HLT=0), MEM_LAT/EX_TIMEOUT defaults.
//  Sub-module cpu_ir_decode: combinational IR -> class (mem/reg/ldi/nop/hlt) + one-hot op vector.
//  Top: FSM, MEM_LAT wait counter, timeout counter, retired counter, registered strobes.
// TESTING
//  Reset mid-EXEC of ADD -> all outputs 0 same cycle, state 0, o_retired 0.
//  i_start, IR=0x1005 (LDA direct), done after 3 EXEC cycles -> o_load+o_is_dir+o_execute 3 cycles, o_retired=1.
//  IR=0x8123 (ADD indirect) -> o_is_ind 1 cycle, EXEC 1+MEM_LAT cycles later with o_add.
//  IR=0x7E00 (CLA|CLE|CMA) -> only o_clr_ac; IR=0x7001 -> o_halted, o_retired incremented.
//  IR=0x5000 (op 101) -> no strobes, FETCH after DECODE, o_retired+1.
//  ISZ, i_ex_done held low 15 cycles -> o_err=1, HALT; i_start clears o_err, pulses o_clr_reg.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator-machine control unit.
// Contents: state encoding, opcodes, IR bit positions, decode classes,
// the one-hot op strobe bundle, and default timing parameters.
package cpu_ctrl_pkg;

    localparam int MEM_LAT_DEF    = 2;
    localparam int EX_TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_IR = 3'd2,
        S_DECODE  = 3'd3,
        S_INDIR   = 3'd4,
        S_WAIT_EA = 3'd5,
        S_EXEC    = 3'd6,
        S_HALT    = 3'd7
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_LDA  = 3'd1;
    localparam logic [2:0] OP_STA  = 3'd2;
    localparam logic [2:0] OP_BUN  = 3'd3;
    localparam logic [2:0] OP_ISZ  = 3'd4;
    localparam logic [2:0] OP_RREF = 3'd7;

    localparam int IR_I   = 15;
    localparam int IR_CLA = 11;
    localparam int IR_CLE = 10;
    localparam int IR_CMA = 9;
    localparam int IR_CIR = 7;
    localparam int IR_CIL = 6;
    localparam int IR_INC = 5;
    localparam int IR_HLT = 0;

    typedef enum logic [2:0] {
        C_NOP = 3'd0,
        C_MEM = 3'd1,
        C_REG = 3'd2,
        C_LDI = 3'd3,
        C_HLT = 3'd4
    } cls_e;

    typedef struct packed {
        logic clr_ac;
        logic clr_e;
        logic comp_ac;
        logic load_ac;
        logic cir_r;
        logic cir_l;
        logic inc_ac;
        logic add;
        logic load;
        logic store;
        logic branch;
        logic isz;
    } ops_t;

endpackage

// File: rtl/cpu_ctrl_unit_ir_decode.sv
// Combinational IR decoder: instruction class plus one-hot op strobes.
// Ports: i_ir (16-bit instruction) -> o_cls (class), o_ops (op strobes).
module cpu_ir_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] i_ir,
    output cls_e        o_cls,
    output ops_t        o_ops
);

    // IR[8] and IR[4:1] carry no register-reference meaning.
    logic unused_bits;
    assign unused_bits = ^{i_ir[8], i_ir[4:1]};

    always_comb begin
        o_cls = C_NOP;
        o_ops = '0;
        case (i_ir[14:12])
            OP_ADD: begin o_cls = C_MEM; o_ops.add    = 1'b1; end
            OP_LDA: begin o_cls = C_MEM; o_ops.load   = 1'b1; end
            OP_STA: begin o_cls = C_MEM; o_ops.store  = 1'b1; end
            OP_BUN: begin o_cls = C_MEM; o_ops.branch = 1'b1; end
            OP_ISZ: begin o_cls = C_MEM; o_ops.isz    = 1'b1; end
            OP_RREF: begin
                if (i_ir[IR_I]) begin
                    o_cls         = C_LDI;
                    o_ops.load_ac = 1'b1;
                end else begin
                    o_cls = C_REG;
                    // HLT wins outright; otherwise highest set bit only.
                    priority case (1'b1)
                        i_ir[IR_HLT]: o_cls         = C_HLT;
                        i_ir[IR_CLA]: o_ops.clr_ac  = 1'b1;
                        i_ir[IR_CLE]: o_ops.clr_e   = 1'b1;
                        i_ir[IR_CMA]: o_ops.comp_ac = 1'b1;
                        i_ir[IR_CIR]: o_ops.cir_r   = 1'b1;
                        i_ir[IR_CIL]: o_ops.cir_l   = 1'b1;
                        i_ir[IR_INC]: o_ops.inc_ac  = 1'b1;
                        default:      o_cls         = C_NOP;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// Control sequencer: fetch / decode / indirect / execute with timeout.
// Ports: clk, i_clr_reg (async reset), i_start, i_ir, i_ex_done in;
// phase strobes, op strobes, o_halted, o_err, o_state, o_retired out.
module cpu_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int EX_TIMEOUT = EX_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             i_clr_reg,
    input  logic             i_start,
    input  logic [15:0]      i_ir,
    input  logic             i_ex_done,
    output logic             o_clr_reg,
    output logic             o_fetch,
    output logic             o_execute,
    output logic             o_is_ind,
    output logic             o_is_dir,
    output logic             o_clr_ac,
    output logic             o_clr_e,
    output logic             o_comp_ac,
    output logic             o_load_ac,
    output logic             o_cir_r,
    output logic             o_cir_l,
    output logic             o_inc_ac,
    output logic             o_add,
    output logic             o_load,
    output logic             o_store,
    output logic             o_branch,
    output logic             o_isz,
    output logic             o_halted,
    output logic             o_err,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    localparam logic [3:0]       LAT_M1  = 4'(MEM_LAT - 1);
    localparam logic [3:0]       TMO_M1  = 4'(EX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RET_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             err_q, err_d;
    ops_t             ops_q, ops_d;
    logic             clr_q, clr_d;
    logic             fetch_q, fetch_d;
    logic             exe_q, exe_d;
    logic             ind_q, ind_d;
    logic             dir_q, dir_d;
    logic             halt_q, halt_d;
    cls_e             dec_cls;
    ops_t             dec_ops;

    // The op register captures IR in DECODE; decoding the next value
    // lets the registered strobes line up with the EXEC state.
    assign ir_d = (state_q == S_DECODE) ? i_ir : ir_q;

    cpu_ir_decode u_dec (
        .i_ir  (ir_d),
        .o_cls (dec_cls),
        .o_ops (dec_ops)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        ret_d   = ret_q;
        err_d   = err_q;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (i_start) begin
                    clr_d   = 1'b1;
                    ret_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                wcnt_d  = '0;
                state_d = S_WAIT_IR;
            end
            S_WAIT_IR: begin
                if (wcnt_q == LAT_M1) state_d = S_DECODE;
                else                  wcnt_d  = wcnt_q + 4'd1;
            end
            S_DECODE: begin
                tcnt_d = '0;
                case (dec_cls)
                    C_MEM:        state_d = ir_d[IR_I] ? S_INDIR : S_EXEC;
                    C_REG, C_LDI: state_d = S_EXEC;
                    C_HLT: begin
                        ret_d   = ret_q + RET_ONE;
                        state_d = S_HALT;
                    end
                    default: begin
                        ret_d   = ret_q + RET_ONE;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_INDIR: begin
                wcnt_d  = '0;
                state_d = S_WAIT_EA;
            end
            S_WAIT_EA: begin
                if (wcnt_q == LAT_M1) state_d = S_EXEC;
                else                  wcnt_d  = wcnt_q + 4'd1;
            end
            S_EXEC: begin
                // tcnt_q == 0 marks the first cycle, where done is stale.
                if (i_ex_done && (tcnt_q != 4'd0)) begin
                    ret_d   = ret_q + RET_ONE;
                    state_d = S_FETCH;
                end else if (tcnt_q == TMO_M1) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        exe_d   = (state_d == S_EXEC);
        fetch_d = (state_d == S_FETCH);
        ind_d   = (state_d == S_INDIR);
        halt_d  = (state_d == S_HALT);
        dir_d   = exe_d && (dec_cls == C_MEM);
        ops_d   = exe_d ? dec_ops : '0;
    end

    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            ops_q   <= '0;
            clr_q   <= 1'b0;
            fetch_q <= 1'b0;
            exe_q   <= 1'b0;
            ind_q   <= 1'b0;
            dir_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
            ops_q   <= ops_d;
            clr_q   <= clr_d;
            fetch_q <= fetch_d;
            exe_q   <= exe_d;
            ind_q   <= ind_d;
            dir_q   <= dir_d;
            halt_q  <= halt_d;
        end
    end

    assign o_clr_reg = clr_q;
    assign o_fetch   = fetch_q;
    assign o_execute = exe_q;
    assign o_is_ind  = ind_q;
    assign o_is_dir  = dir_q;
    assign o_clr_ac  = ops_q.clr_ac;
    assign o_clr_e   = ops_q.clr_e;
    assign o_comp_ac = ops_q.comp_ac;
    assign o_load_ac = ops_q.load_ac;
    assign o_cir_r   = ops_q.cir_r;
    assign o_cir_l   = ops_q.cir_l;
    assign o_inc_ac  = ops_q.inc_ac;
    assign o_add     = ops_q.add;
    assign o_load    = ops_q.load;
    assign o_store   = ops_q.store;
    assign o_branch  = ops_q.branch;
    assign o_isz     = ops_q.isz;
    assign o_halted  = halt_q;
    assign o_err     = err_q;
    assign o_state   = state_q;
    assign o_retired = ret_q;

endmodule
